// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, performs it after a
// programmable latency and returns data plus an error flag on a valid/ready channel.
module dmem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int CW    = $clog2(LATENCY + 1);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic                    err_q, err_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [3:0]              be_q, be_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [31:0]             rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    access;
    logic                    mem_wr;

    logic [31:0] mem [0:DEPTH-1];

    assign req_ready = (state_q == S_IDLE) && !reset;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // The access happens on the last WAIT edge; errored requests never touch the array.
    assign access = (state_q == S_WAIT) && (cnt_q == '0);
    assign mem_wr = access && we_q && !err_q && !reset;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        err_d       = err_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    idx_d   = req_addr[ADDR_WIDTH+1:2];
                    err_d   = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_WIDTH+2] != '0);
                    cnt_d   = CNT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_q;
                    rsp_rdata_d = (err_q || we_q) ? 32'h0 : mem[idx_q];
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= 32'h0;
            be_q        <= 4'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            err_q       <= err_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Array contents survive reset, so the write port has no reset branch.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 main instance plus LATENCY=1 and 5 builds.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [2:0]  rsp_valid;
    logic [2:0]  rsp_err;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_ready;
    logic [31:0] rdata [3];

    int errors = 0;
    int checks = 0;
    int lat_of [3] = '{2, 1, 5};

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_l2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready),
        .rsp_rdata(rdata[0]), .rsp_err(rsp_err[0])
    );
    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready),
        .rsp_rdata(rdata[1]), .rsp_err(rsp_err[1])
    );
    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(5)) u_l5 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready),
        .rsp_rdata(rdata[2]), .rsp_err(rsp_err[2])
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t tbl [12];
    vec_t tbl_x [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request to instance k and check latency, response and handshake.
    task automatic run_txn(input int k, input vec_t v);
        int  lat;
        bit  got;
        @(negedge clk);
        req_we = v.we; req_addr = v.addr; req_wdata = v.wdata; req_be = v.be;
        rsp_ready = 1'b0;
        req_valid[k] = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (req_ready[k]) got = 1;
            else @(negedge clk);
        end
        chk("accept_timeout", 32'(got), 32'd1);
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        lat = 0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (rsp_valid[k]) got = 1;
            else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        chk("latency", 32'(lat), 32'(lat_of[k]));
        chk("rsp_rdata", rdata[k], v.exp_rd);
        chk("rsp_err", 32'(rsp_err[k]), 32'(v.exp_err));
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", 32'(rsp_valid[k]), 32'd0);
        chk("rsp_rdata_clear", rdata[k], 32'h0);
        $display("txn L=%0d we=%0b addr=0x%08h wdata=0x%08h be=%b -> lat=%0d rdata=0x%08h err=%0b",
                 lat_of[k], v.we, v.addr, v.wdata, v.be, lat, v.exp_rd, v.exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h10,   32'h11223344, 4'h5, 32'h0,        1'b0};
        tbl[3]  = '{1'b0, 32'h10,   32'h0,        4'hF, 32'hDE22BE44, 1'b0};
        tbl[4]  = '{1'b1, 32'h12,   32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
        tbl[5]  = '{1'b0, 32'h1000, 32'h0,        4'h0, 32'h0,        1'b1};
        tbl[6]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDE22BE44, 1'b0};
        tbl[7]  = '{1'b1, 32'h10,   32'h0,        4'h0, 32'h0,        1'b0};
        tbl[8]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDE22BE44, 1'b0};
        tbl[9]  = '{1'b1, 32'h20,   32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
        tbl[10] = '{1'b1, 32'hFFC,  32'h0BADC0DE, 4'hF, 32'h0,        1'b0};
        tbl[11] = '{1'b0, 32'hFFC,  32'h0,        4'h0, 32'h0BADC0DE, 1'b0};
        tbl_x[0] = '{1'b1, 32'h40,  32'hA5A50001, 4'hF, 32'h0,        1'b0};
        tbl_x[1] = '{1'b0, 32'h40,  32'h0,        4'h0, 32'hA5A50001, 1'b0};
        tbl_x[2] = '{1'b1, 32'h40,  32'h77665544, 4'hA, 32'h0,        1'b0};
        tbl_x[3] = '{1'b0, 32'h40,  32'h0,        4'h0, 32'h77A55501, 1'b0};

        reset = 1'b1; req_valid = 3'b000; req_we = 1'b0; req_addr = 32'h0;
        req_wdata = 32'h0; req_be = 4'h0; rsp_ready = 1'b0;
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rsp_err", 32'(rsp_err), 32'h0);
        chk("reset_rsp_rdata", rdata[0], 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_reset_req_ready", 32'(req_ready), 32'h7);

        for (int i = 0; i < 12; i++) run_txn(0, tbl[i]);

        // Back-pressure: response held 5 cycles while a second request waits.
        @(negedge clk);
        req_we = 1'b0; req_addr = 32'h10; req_valid[0] = 1'b1; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("bp_rsp_valid", 32'(rsp_valid[0]), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) begin
                req_addr = 32'h20; req_we = 1'b0; req_valid[0] = 1'b1;
            end
            chk("bp_hold_valid", 32'(rsp_valid[0]), 32'd1);
            chk("bp_hold_rdata", rdata[0], 32'hDE22BE44);
            chk("bp_req_ready", 32'(req_ready[0]), 32'd0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("bp_handshake_valid", 32'(rsp_valid[0]), 32'd0);
        chk("bp_idle_ready", 32'(req_ready[0]), 32'd1);
        @(posedge clk); #1;
        chk("bp_second_accepted", 32'(req_ready[0]), 32'd0);
        req_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("bp_second_valid", 32'(rsp_valid[0]), 32'd1);
        chk("bp_second_rdata", rdata[0], 32'hCAFEF00D);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        $display("txn L=2 backpressure load 0x10 then queued load 0x20 done");

        // Reset while a store is still waiting for its access edge.
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'hF;
        req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst_req_ready", 32'(req_ready[0]), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("midrst_idle_ready", 32'(req_ready[0]), 32'd1);
        $display("txn L=2 reset during pending store 0x20");
        run_txn(0, '{1'b0, 32'h20, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0});

        for (int k = 1; k < 3; k++) begin
            for (int i = 0; i < 4; i++) run_txn(k, tbl_x[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
